// File: rtl/hessian_3d_edge_if.sv
// Neighbourhood-in / Hessian-out bundle for the SIFT 3D Hessian and edge-test stage.
// A transfer happens on a rising iclk edge when the producer's valid and the consumer's ready are both 1; valid never waits on ready.
interface hessian_3d_edge_if #(
   parameter int DATA_W = 9,
   parameter int OUT_W  = 9
);
   logic ivalid;
   logic oready;
   logic ovalid;
   logic iready;

   logic signed [DATA_W-1:0] iData_mid_top_left, iData_mid_top, iData_mid_top_right;
   logic signed [DATA_W-1:0] iData_mid_left, iData_mid, iData_mid_right;
   logic signed [DATA_W-1:0] iData_mid_bot_left, iData_mid_bot, iData_mid_bot_right;
   logic signed [DATA_W-1:0] iData_pre_top, iData_pre_left, iData_pre, iData_pre_right, iData_pre_bot;
   logic signed [DATA_W-1:0] iData_next_top, iData_next_left, iData_next, iData_next_right, iData_next_bot;

   logic signed [OUT_W-1:0] odxx, odyy, odss, odxy, odxs, odys;
   logic signed [OUT_W:0]   otrace;
   logic signed [2*OUT_W:0] odet;
   logic                    oedge;
   logic                    osat;

   modport master (
      output ivalid, iready,
      output iData_mid_top_left, iData_mid_top, iData_mid_top_right,
      output iData_mid_left, iData_mid, iData_mid_right,
      output iData_mid_bot_left, iData_mid_bot, iData_mid_bot_right,
      output iData_pre_top, iData_pre_left, iData_pre, iData_pre_right, iData_pre_bot,
      output iData_next_top, iData_next_left, iData_next, iData_next_right, iData_next_bot,
      input  oready, ovalid,
      input  odxx, odyy, odss, odxy, odxs, odys, otrace, odet, oedge, osat
   );

   modport slave (
      input  ivalid, iready,
      input  iData_mid_top_left, iData_mid_top, iData_mid_top_right,
      input  iData_mid_left, iData_mid, iData_mid_right,
      input  iData_mid_bot_left, iData_mid_bot, iData_mid_bot_right,
      input  iData_pre_top, iData_pre_left, iData_pre, iData_pre_right, iData_pre_bot,
      input  iData_next_top, iData_next_left, iData_next, iData_next_right, iData_next_bot,
      output oready, ovalid,
      output odxx, odyy, odss, odxy, odxs, odys, otrace, odet, oedge, osat
   );
endinterface

// File: rtl/hessian_3d_edge.sv
// 3-stage DoG Hessian: second derivatives and cross terms, then trace/determinant,
// then Lowe's edge-response test. Whole pipeline stalls together when the output is held.
module hessian_3d_edge #(
   parameter int DATA_W = 9,
   parameter int OUT_W  = 9,
   parameter int EDGE_R = 10,
   parameter int SAT_EN = 1
) (
   input  logic             iclk,
   input  logic             irst,
   hessian_3d_edge_if.slave bus
);
   localparam int SW    = DATA_W + 2;
   localparam int WW    = (SW > OUT_W) ? SW : OUT_W;
   localparam int DW    = 2*OUT_W + 1;
   // One bit beyond the nominal compare width so det at its extreme with r=31 cannot wrap.
   localparam int CMP_W = 2*(OUT_W+1) + 7;
   localparam logic signed [WW-1:0] OMAX = WW'((2**(OUT_W-1)) - 1);
   localparam logic signed [WW-1:0] OMIN = WW'(-(2**(OUT_W-1)));
   localparam logic [CMP_W-1:0] R_L  = CMP_W'(EDGE_R);
   localparam logic [CMP_W-1:0] R1SQ = CMP_W'((EDGE_R+1)*(EDGE_R+1));

   logic adv, v1, v2, v3;

   assign adv        = ~v3 | bus.iready;
   assign bus.oready = adv;
   assign bus.ovalid = v3;

   logic signed [SW-1:0]    d2_raw [3];
   logic signed [WW-1:0]    d2_wide;
   logic signed [OUT_W-1:0] d2_n [3];
   logic [2:0]              clamp;
   logic signed [SW-1:0]    xy_raw, xs_raw, ys_raw;

   always_comb begin
      d2_raw[0] = SW'(bus.iData_mid_right) + SW'(bus.iData_mid_left) - (SW'(bus.iData_mid) <<< 1);
      d2_raw[1] = SW'(bus.iData_mid_bot) + SW'(bus.iData_mid_top) - (SW'(bus.iData_mid) <<< 1);
      d2_raw[2] = SW'(bus.iData_next) + SW'(bus.iData_pre) - (SW'(bus.iData_mid) <<< 1);
      xy_raw = (SW'(bus.iData_mid_bot_right) - SW'(bus.iData_mid_bot_left))
             + (SW'(bus.iData_mid_top_left) - SW'(bus.iData_mid_top_right));
      xs_raw = (SW'(bus.iData_next_right) - SW'(bus.iData_next_left))
             + (SW'(bus.iData_pre_left) - SW'(bus.iData_pre_right));
      ys_raw = (SW'(bus.iData_next_bot) - SW'(bus.iData_next_top))
             + (SW'(bus.iData_pre_top) - SW'(bus.iData_pre_bot));
      d2_wide = '0;
      clamp   = '0;
      for (int i = 0; i < 3; i++) begin
         d2_wide = WW'(d2_raw[i]);
         d2_n[i] = d2_wide[OUT_W-1:0];
         if (SAT_EN != 0) begin
            if (d2_wide > OMAX) begin
               d2_n[i]  = OMAX[OUT_W-1:0];
               clamp[i] = 1'b1;
            end else if (d2_wide < OMIN) begin
               d2_n[i]  = OMIN[OUT_W-1:0];
               clamp[i] = 1'b1;
            end
         end
      end
   end

   logic signed [OUT_W-1:0] s1_d2 [3];
   logic signed [OUT_W-1:0] s1_xy, s1_xs, s1_ys;
   logic                    s1_sat;

   logic signed [OUT_W:0]   trace_n;
   logic signed [DW-1:0]    det_n;

   always_comb begin
      trace_n = (OUT_W+1)'(s1_d2[0]) + (OUT_W+1)'(s1_d2[1]);
      det_n   = DW'(s1_d2[0]) * DW'(s1_d2[1]) - DW'(s1_xy) * DW'(s1_xy);
   end

   logic signed [OUT_W-1:0] s2_dxx, s2_dyy, s2_dss, s2_xy, s2_xs, s2_ys;
   logic signed [OUT_W:0]   s2_trace;
   logic signed [DW-1:0]    s2_det;
   logic                    s2_sat;

   logic [OUT_W:0]   tr_mag;
   logic [CMP_W-1:0] lhs, rhs;
   logic             det_pos, edge_n;

   // Both sides are non-negative once det > 0, so the ratio test is an unsigned compare.
   always_comb begin
      tr_mag  = s2_trace[OUT_W] ? $unsigned(-s2_trace) : $unsigned(s2_trace);
      lhs     = CMP_W'(tr_mag) * CMP_W'(tr_mag) * R_L;
      rhs     = R1SQ * CMP_W'(s2_det[DW-2:0]);
      det_pos = ~s2_det[DW-1] & (|s2_det);
      edge_n  = ~det_pos | (lhs >= rhs);
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         for (int i = 0; i < 3; i++) s1_d2[i] <= '0;
         s1_xy    <= '0;
         s1_xs    <= '0;
         s1_ys    <= '0;
         s1_sat   <= 1'b0;
         s2_dxx   <= '0;
         s2_dyy   <= '0;
         s2_dss   <= '0;
         s2_xy    <= '0;
         s2_xs    <= '0;
         s2_ys    <= '0;
         s2_trace <= '0;
         s2_det   <= '0;
         s2_sat   <= 1'b0;
         bus.odxx   <= '0;
         bus.odyy   <= '0;
         bus.odss   <= '0;
         bus.odxy   <= '0;
         bus.odxs   <= '0;
         bus.odys   <= '0;
         bus.otrace <= '0;
         bus.odet   <= '0;
         bus.oedge  <= 1'b0;
         bus.osat   <= 1'b0;
      end else if (adv) begin
         v1 <= bus.ivalid;
         for (int i = 0; i < 3; i++) s1_d2[i] <= d2_n[i];
         s1_xy  <= OUT_W'(xy_raw >>> 2);
         s1_xs  <= OUT_W'(xs_raw >>> 2);
         s1_ys  <= OUT_W'(ys_raw >>> 2);
         s1_sat <= |clamp;

         v2       <= v1;
         s2_dxx   <= s1_d2[0];
         s2_dyy   <= s1_d2[1];
         s2_dss   <= s1_d2[2];
         s2_xy    <= s1_xy;
         s2_xs    <= s1_xs;
         s2_ys    <= s1_ys;
         s2_trace <= trace_n;
         s2_det   <= det_n;
         s2_sat   <= s1_sat;

         v3         <= v2;
         bus.odxx   <= s2_dxx;
         bus.odyy   <= s2_dyy;
         bus.odss   <= s2_dss;
         bus.odxy   <= s2_xy;
         bus.odxs   <= s2_xs;
         bus.odys   <= s2_ys;
         bus.otrace <= s2_trace;
         bus.odet   <= s2_det;
         bus.oedge  <= edge_n;
         bus.osat   <= s2_sat;
      end
   end
endmodule

// File: tb/tb_hessian_3d_edge.sv
// Directed bench for hessian_3d_edge: a saturating and a truncating instance share stimulus;
// a monitor pops expected bundles from a queue on every output transfer.
module tb_hessian_3d_edge;
   localparam int DATA_W = 9;
   localparam int OUT_W  = 9;

   localparam int MTL = 0, MT = 1, MTR = 2, ML = 3, MC = 4, MR = 5, MBL = 6, MB = 7, MBR = 8;
   localparam int PT = 9, PL = 10, PC = 11, PR = 12, PB = 13;
   localparam int NT = 14, NL = 15, NC = 16, NR = 17, NB = 18;

   typedef logic [18:0][DATA_W-1:0] vec_t;

   typedef struct packed {
      logic signed [8:0]  dxx, dyy, dss, dxy, dxs, dys;
      logic signed [9:0]  trace;
      logic signed [18:0] det;
      logic               edge_f;
      logic               sat;
      logic signed [8:0]  t_dxx;
      logic               t_sat;
   } exp_t;

   localparam int EW = $bits(exp_t);

   logic iclk = 1'b0;
   logic irst;
   always #5 iclk = ~iclk;

   hessian_3d_edge_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();
   hessian_3d_edge_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus_t ();

   hessian_3d_edge #(.DATA_W(DATA_W), .OUT_W(OUT_W), .EDGE_R(10), .SAT_EN(1))
      u_dut (.iclk(iclk), .irst(irst), .bus(bus));
   hessian_3d_edge #(.DATA_W(DATA_W), .OUT_W(OUT_W), .EDGE_R(10), .SAT_EN(0))
      u_trunc (.iclk(iclk), .irst(irst), .bus(bus_t));

   assign bus_t.ivalid              = bus.ivalid;
   assign bus_t.iready              = bus.iready;
   assign bus_t.iData_mid_top_left  = bus.iData_mid_top_left;
   assign bus_t.iData_mid_top       = bus.iData_mid_top;
   assign bus_t.iData_mid_top_right = bus.iData_mid_top_right;
   assign bus_t.iData_mid_left      = bus.iData_mid_left;
   assign bus_t.iData_mid           = bus.iData_mid;
   assign bus_t.iData_mid_right     = bus.iData_mid_right;
   assign bus_t.iData_mid_bot_left  = bus.iData_mid_bot_left;
   assign bus_t.iData_mid_bot       = bus.iData_mid_bot;
   assign bus_t.iData_mid_bot_right = bus.iData_mid_bot_right;
   assign bus_t.iData_pre_top       = bus.iData_pre_top;
   assign bus_t.iData_pre_left      = bus.iData_pre_left;
   assign bus_t.iData_pre           = bus.iData_pre;
   assign bus_t.iData_pre_right     = bus.iData_pre_right;
   assign bus_t.iData_pre_bot       = bus.iData_pre_bot;
   assign bus_t.iData_next_top      = bus.iData_next_top;
   assign bus_t.iData_next_left     = bus.iData_next_left;
   assign bus_t.iData_next          = bus.iData_next;
   assign bus_t.iData_next_right    = bus.iData_next_right;
   assign bus_t.iData_next_bot      = bus.iData_next_bot;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   vec_t vecs[10];
   exp_t exps[10];
   int bp_idx[6] = '{0, 3, 7, 8, 1, 9};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk_exp(int dxx, int dyy, int dss, int dxy, int dxs, int dys,
                                   int tr, int det, int edg, int sat, int t_dxx, int t_sat);
      exp_t e;
      e.dxx = 9'(dxx);   e.dyy = 9'(dyy);   e.dss = 9'(dss);
      e.dxy = 9'(dxy);   e.dxs = 9'(dxs);   e.dys = 9'(dys);
      e.trace = 10'(tr); e.det = 19'(det);
      e.edge_f = 1'(edg); e.sat = 1'(sat);
      e.t_dxx = 9'(t_dxx); e.t_sat = 1'(t_sat);
      return e;
   endfunction

   function automatic exp_t cur_out();
      exp_t c;
      c.dxx = bus.odxx;   c.dyy = bus.odyy;   c.dss = bus.odss;
      c.dxy = bus.odxy;   c.dxs = bus.odxs;   c.dys = bus.odys;
      c.trace = bus.otrace; c.det = bus.odet;
      c.edge_f = bus.oedge; c.sat = bus.osat;
      c.t_dxx = bus_t.odxx; c.t_sat = bus_t.osat;
      return c;
   endfunction

   task automatic drive_vec(input vec_t v);
      bus.iData_mid_top_left  = v[MTL];
      bus.iData_mid_top       = v[MT];
      bus.iData_mid_top_right = v[MTR];
      bus.iData_mid_left      = v[ML];
      bus.iData_mid           = v[MC];
      bus.iData_mid_right     = v[MR];
      bus.iData_mid_bot_left  = v[MBL];
      bus.iData_mid_bot       = v[MB];
      bus.iData_mid_bot_right = v[MBR];
      bus.iData_pre_top       = v[PT];
      bus.iData_pre_left      = v[PL];
      bus.iData_pre           = v[PC];
      bus.iData_pre_right     = v[PR];
      bus.iData_pre_bot       = v[PB];
      bus.iData_next_top      = v[NT];
      bus.iData_next_left     = v[NL];
      bus.iData_next          = v[NC];
      bus.iData_next_right    = v[NR];
      bus.iData_next_bot      = v[NB];
   endtask

   // Presents one sample and returns right after the edge that accepts it.
   task automatic send(input vec_t v, input exp_t e);
      int n = 0;
      @(negedge iclk);
      drive_vec(v);
      bus.ivalid = 1'b1;
      #1;
      while (!bus.oready && n < 100) begin
         @(negedge iclk);
         #1;
         n++;
      end
      if (n >= 100) chk("send_timeout", 128'(n), 128'(0));
      exp_q.push_back(e);
      @(posedge iclk);
   endtask

   task automatic idle();
      @(negedge iclk);
      bus.ivalid = 1'b0;
   endtask

   task automatic expect_latency(input int want);
      int n = 0;
      do begin
         @(negedge iclk);
         bus.ivalid = 1'b0;
         #1;
         n++;
      end while (!bus.ovalid && n < 20);
      chk("latency", 128'(n), 128'(want));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge iclk);
         n++;
      end
      chk("drain_left", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ovalid"}, 128'(bus.ovalid), 128'(0));
      chk({tag, "_outs"}, 128'(cur_out()), 128'(0));
   endtask

   // Monitor: transfers are judged just after the falling edge, when inputs are settled.
   initial begin : monitor
      exp_t e, a, snap;
      logic held;
      held = 1'b0;
      snap = '0;
      forever begin
         @(negedge iclk);
         #2;
         if (irst) begin
            held = 1'b0;
            continue;
         end
         a = cur_out();
         if (held && bus.ovalid) chk("hold_stable", 128'(a), 128'(snap));
         if (bus.ovalid && bus.iready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 128'(1), 128'(0));
            end else begin
               e = exp_t'(exp_q.pop_front());
               chk("dxx", 128'(a.dxx), 128'(e.dxx));
               chk("dyy", 128'(a.dyy), 128'(e.dyy));
               chk("dss", 128'(a.dss), 128'(e.dss));
               chk("dxy", 128'(a.dxy), 128'(e.dxy));
               chk("dxs", 128'(a.dxs), 128'(e.dxs));
               chk("dys", 128'(a.dys), 128'(e.dys));
               chk("trace", 128'(a.trace), 128'(e.trace));
               chk("det", 128'(a.det), 128'(e.det));
               chk("edge", 128'(a.edge_f), 128'(e.edge_f));
               chk("sat", 128'(a.sat), 128'(e.sat));
               chk("trunc_dxx", 128'(a.t_dxx), 128'(e.t_dxx));
               chk("trunc_sat", 128'(a.t_sat), 128'(e.t_sat));
            end
         end else if (bus.ovalid) begin
            held = 1'b1;
            snap = a;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      for (int i = 0; i < 10; i++) vecs[i] = '0;
      vecs[0][MC] = 9'd10;
      vecs[1][MC] = 9'd10;  vecs[1][MT] = 9'd10;  vecs[1][MB] = 9'd10;
      vecs[2][MC] = 9'd10;  vecs[2][MT] = 9'd20;  vecs[2][MB] = 9'd20;
      vecs[3][MBR] = 9'd100;
      vecs[4][MBL] = 9'd3;
      vecs[5][NB] = 9'(-8);
      vecs[6][MC] = 9'(-256); vecs[6][ML] = 9'd255; vecs[6][MR] = 9'd255;
      vecs[7][MC] = 9'd10;  vecs[7][MT] = 9'd9;   vecs[7][MB] = 9'd9;
      vecs[8][MC] = 9'd20;  vecs[8][MTL] = 9'd7;  vecs[8][NR] = 9'd13; vecs[8][PT] = 9'(-5);
      vecs[9][MC] = 9'd255; vecs[9][ML] = 9'(-256); vecs[9][MR] = 9'(-256);

      exps[0] = mk_exp(-20, -20, -20, 0, 0, 0, -40, 400, 0, 0, -20, 0);
      exps[1] = mk_exp(-20, 0, -20, 0, 0, 0, -20, 0, 1, 0, -20, 0);
      exps[2] = mk_exp(-20, 20, -20, 0, 0, 0, 0, -400, 1, 0, -20, 0);
      exps[3] = mk_exp(0, 0, 0, 25, 0, 0, 0, -625, 1, 0, 0, 0);
      exps[4] = mk_exp(0, 0, 0, -1, 0, 0, 0, -1, 1, 0, 0, 0);
      exps[5] = mk_exp(0, 0, 0, 0, 0, -2, 0, 0, 1, 0, 0, 0);
      exps[6] = mk_exp(255, 255, 255, 0, 0, 0, 510, 65025, 0, 1, -2, 0);
      exps[7] = mk_exp(-20, -2, -20, 0, 0, 0, -22, 40, 1, 0, -20, 0);
      exps[8] = mk_exp(-40, -40, -40, 1, 3, -2, -80, 1599, 0, 0, -40, 0);
      exps[9] = mk_exp(-256, -256, -256, 0, 0, 0, -512, 65536, 0, 1, 2, 0);

      irst = 1'b1;
      bus.ivalid = 1'b0;
      bus.iready = 1'b1;
      drive_vec('0);
      repeat (3) @(negedge iclk);
      #1;
      chk_outputs_zero("reset");
      @(negedge iclk);
      irst = 1'b0;
      #1;
      chk("reset_oready", 128'(bus.oready), 128'(1));

      send(vecs[0], exps[0]);
      expect_latency(3);
      wait_drain();

      for (int i = 1; i < 10; i++) send(vecs[i], exps[i]);
      idle();
      wait_drain();

      fork
         begin
            for (int i = 0; i < 6; i++) send(vecs[bp_idx[i]], exps[bp_idx[i]]);
            idle();
         end
         begin
            repeat (2) @(negedge iclk);
            bus.iready = 1'b0;
            repeat (2) @(negedge iclk);
            #1;
            chk("bp_oready_low", 128'(bus.oready), 128'(0));
            chk("bp_ovalid_high", 128'(bus.ovalid), 128'(1));
            repeat (6) @(negedge iclk);
            bus.iready = 1'b1;
         end
      join
      wait_drain();

      send(vecs[0], exps[0]);
      send(vecs[3], exps[3]);
      send(vecs[8], exps[8]);
      @(negedge iclk);
      irst = 1'b1;
      bus.ivalid = 1'b0;
      @(negedge iclk);
      irst = 1'b0;
      exp_q.delete();
      #1;
      chk_outputs_zero("midreset");
      send(vecs[7], exps[7]);
      expect_latency(3);
      wait_drain();

      repeat (3) @(negedge iclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hessian_3d_edge.md
Name: hessian_3d_edge

Overview:
- Parametrised, pipelined successor to the fixed 9-bit DoG Hessian stage in the SIFT detection path.
- Takes the 19-sample 3x3x3 DoG neighbourhood of one candidate extremum and produces the six Hessian terms dxx, dyy, dss, dxy, dxs, dys.
- Computes the 2D spatial trace and determinant and applies Lowe's edge-response test, so each sample leaves with an edge-reject flag.
- Adds valid/ready flow control and saturating arithmetic. Sits between the extremum detector and the keypoint refinement / solver stage.

Parameters:
- DATA_W, 9, signed width of every DoG input sample.
- OUT_W, 9, signed width of each Hessian output term; OUT_W >= DATA_W.
- EDGE_R, 10, curvature ratio r for the edge test (unsigned integer, 1..31).
- SAT_EN, 1, 1 = clamp second derivatives to the OUT_W range; 0 = truncate to the low OUT_W bits.

Ports:
- iclk  in  1  clock.
- irst  in  1  synchronous active-high reset.
- ivalid  in  1  upstream neighbourhood valid.
- oready  out  1  block can accept a sample this cycle.
- iData_mid_top_left .. iData_mid_bot_right  in  DATA_W each, signed  9 mid-scale samples.
- iData_pre_top/left/(centre)/right/bot  in  DATA_W each, signed  5 previous-scale samples.
- iData_next_top/left/(centre)/right/bot  in  DATA_W each, signed  5 next-scale samples.
- ovalid  out  1  output bundle valid.
- iready  in  1  downstream ready.
- odxx, odyy, odss, odxy, odxs, odys  out  OUT_W each, signed  Hessian terms.
- otrace  out  OUT_W+1, signed  dxx + dyy.
- odet  out  2*OUT_W+1, signed  dxx*dyy - dxy^2.
- oedge  out  1  1 = reject as edge or saddle.
- osat  out  1  1 = at least one of dxx, dyy, dss was clamped for this sample.

Behaviour:
- Reset and clocking: one clock, synchronous active-high reset. On irst, all stage valids and all outputs go to 0 and in-flight samples are discarded (no partial output). oready is 1 in the first cycle after reset.
- Pipeline: 3 stages, latency 3 cycles from an accepted sample (ivalid & oready) to ovalid when never stalled. Samples emerge in order, one per cycle maximum.
- Flow control:
  - adv = ~v3 | iready, where v3 is the stage-3 valid; oready = adv.
  - When adv = 0, every stage register and every output holds.
  - Bubbles are not collapsed: oready drops whenever v3 = 1 and iready = 0.
  - ovalid = v3. A transfer occurs on ovalid & iready.
- Stage 1, second derivatives, computed at DATA_W+2 bits:
  - dxx = right + left - 2*mid.
  - dyy = bot + top - 2*mid.
  - dss = next + pre - 2*mid.
  - Each is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when SAT_EN = 1; stage-1 sat bit = OR of the three clamp events.
- Stage 1, cross terms:
  - raw_xy = (bot_right - bot_left) + (top_left - top_right).
  - raw_xs = (next_right - next_left) + (pre_left - pre_right).
  - raw_ys = (next_bot - next_top) + (pre_top - pre_bot).
  - Each is arithmetic-shifted right by 2 (floor toward -inf) and sign-extended to OUT_W. The shifted value always fits in DATA_W, so no saturation is needed.
- Stage 2: trace = dxx + dyy at full width; det = dxx*dyy - dxy*dxy at full width. Hessian terms and the sat bit are carried alongside.
- Stage 3, edge test:
  - oedge = 1 if det <= 0.
  - Otherwise oedge = 1 if trace^2 * EDGE_R >= (EDGE_R+1)^2 * det, else 0.
  - Compare width is 2*(OUT_W+1)+6 bits unsigned; neither side may overflow.
  - All output registers load together on adv.
- ivalid = 0 on an accepted cycle inserts a bubble; downstream data outputs in bubble cycles are don't-care, but ovalid must be 0.

Test Plan:
- Blob: DATA_W=9, mid=10, all other inputs 0 -> after 3 cycles ovalid=1, dxx=dyy=dss=-20, dxy=dxs=dys=0, trace=-40, det=400, oedge=0 (16000 < 48400), osat=0.
- Edge: mid=10, mid_top=mid_bot=10, rest 0 -> dxx=-20, dyy=0, det=0, oedge=1. Saddle: mid_top=mid_bot=20 gives dyy=20, det=-400, oedge=1.
- Cross-term rounding: bot_right=100 only -> dxy=25. bot_left=3 only -> dxy=-1. next_bot=-8 only -> dys=-2.
- Saturation: mid=-256, left=right=255 -> dxx=255, osat=1. Same stimulus with SAT_EN=0 -> dxx equals the low 9 bits of 1022 (-2), osat=0.
- Backpressure: 6 back-to-back samples with iready=0 from cycle 2 to cycle 9 -> oready falls once v3=1; outputs stay stable; no sample is lost or duplicated; all 6 emerge in order after iready=1.
- Reset mid-flight: assert irst for 1 cycle with 3 samples in the pipe -> next cycle ovalid=0 and all outputs 0; the next accepted sample appears exactly 3 cycles later.
